// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner encodings and data width for the memory port arbiter
package mem_port_arbiter_pkg;
   localparam int DW = 32;
   localparam int CW = 4;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
   typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
endpackage

// File: rtl/mem_port_arbiter_latency.sv
// mem_latency_counter: loadable down-counter that saturates at zero and flags it
module mem_latency_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of fixed Dm priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          IfReq,
   input  logic [DW-1:0] IfAddr,
   input  logic          DmReq,
   input  logic          DmWe,
   input  logic [DW-1:0] DmAddr,
   input  logic [DW-1:0] DmWData,
   output logic          IfGnt,
   output logic          DmGnt,
   output logic          IfValid,
   output logic          DmValid,
   output logic [DW-1:0] RData,
   output logic [DW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   output logic          MemRead,
   output logic          MemWrite,
   input  logic [DW-1:0] MemRData,
   output logic          Busy
);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

   state_e        state_q;
   owner_e        owner_q;
   logic          if_gnt_q, dm_gnt_q, if_valid_q, dm_valid_q, rd_q, wr_q;
   logic [DW-1:0] addr_q, wdata_q, rdata_q;
   logic          start, pick_dm, cnt_zero;

   assign start = (state_q == IDLE) && (IfReq || DmReq);

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_q;
   assign pick_dm = DmReq && !(IfReq && last_q == OWN_DM);
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)      last_q <= OWN_DM;
      else if (start) last_q <= pick_dm ? OWN_DM : OWN_IF;
   end
`else
   assign pick_dm = DmReq;
`endif

   mem_latency_counter #(.W(CW)) u_lat (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .load_i     (start),
      .load_val_i (LOAD_VAL),
      .dec_i      (state_q == ACCESS),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         if_gnt_q   <= 1'b0;
         dm_gnt_q   <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         if_gnt_q   <= 1'b0;
         dm_gnt_q   <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               state_q  <= ACCESS;
               owner_q  <= pick_dm ? OWN_DM : OWN_IF;
               addr_q   <= pick_dm ? DmAddr : IfAddr;
               wdata_q  <= pick_dm ? DmWData : '0;
               if_gnt_q <= !pick_dm;
               dm_gnt_q <= pick_dm;
               wr_q     <= pick_dm && DmWe;
               rd_q     <= !(pick_dm && DmWe);
            end
         end else if (cnt_zero) begin
            // last access cycle: sample read data while MemRead is still asserted
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            if_valid_q <= (owner_q == OWN_IF);
            dm_valid_q <= (owner_q == OWN_DM);
            if (rd_q) rdata_q <= MemRData;
         end
      end
   end

   assign IfGnt    = if_gnt_q;
   assign DmGnt    = dm_gnt_q;
   assign IfValid  = if_valid_q;
   assign DmValid  = dm_valid_q;
   assign RData    = rdata_q;
   assign MemAddr  = addr_q;
   assign MemWData = wdata_q;
   assign MemRead  = rd_q;
   assign MemWrite = wr_q;
   assign Busy     = (state_q == ACCESS);
endmodule
